// File: rtl/uart_pkg.sv
// Shared UART package: 12 MHz baud divisor constants used by both the
// transmit- and receive-side baud generators, plus a counter-width helper.
package uart_pkg;

    // System clocks per bit period at a 12 MHz system clock
    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    // Width of a counter that runs 0 .. div-1; never narrower than one bit
    function automatic int divcnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/baud_gen_tx_if.sv
// Enable/tick handshake between the UART transmitter FSM (master) and the
// transmit baud generator (slave).
interface baud_gen_tx_if;
    logic clk_ena;   // transmitter holds this high for the whole frame
    logic clk_out;   // one-clock baud tick per bit period

    modport master (output clk_ena, input clk_out);
    modport slave  (input clk_ena, output clk_out);
endinterface

// File: rtl/baud_gen_tx.sv
// Transmit baud tick generator. Divides clk by BAUDRATE and emits a
// one-clock tick per bit period while enabled. While disabled the counter
// is parked at BAUDRATE-1 so the first tick lands one clock after enable.
// Optional macro BAUDGEN_TX_REG_OUT_EN registers the tick output (glitch-free,
// one extra clock of latency, same period).
module baud_gen_tx
    import uart_pkg::*;
#(
    parameter int BAUDRATE = B115200   // clocks per bit period, must be >= 2
) (
    input  logic           clk,
    input  logic           rstn,
    baud_gen_tx_if.slave   bus
);

    localparam int          N    = divcnt_width(BAUDRATE);
    localparam logic [N-1:0] LAST = N'(BAUDRATE - 1);

    logic [N-1:0] divcounter;
    logic         tick;

    // Divider: reset to 0, wrap modulo BAUDRATE while enabled, pre-arm when idle
    always_ff @(posedge clk) begin
        if (!rstn)
            divcounter <= '0;
        else if (bus.clk_ena)
            divcounter <= (divcounter == LAST) ? '0 : divcounter + N'(1);
        else
            divcounter <= LAST;
    end

    // Tick is gated by enable so a disable kills it in the same cycle
    assign tick = (divcounter == '0) && bus.clk_ena;

`ifdef BAUDGEN_TX_REG_OUT_EN
    logic clk_out_q;

    // Registered tick: cleared by reset, otherwise follows the gated tick
    always_ff @(posedge clk) begin
        if (!rstn)
            clk_out_q <= 1'b0;
        else
            clk_out_q <= tick;
    end

    assign bus.clk_out = clk_out_q;
`else
    assign bus.clk_out = tick;
`endif

endmodule

// File: tb/tb_baud_gen_tx.sv
// Directed bench for baud_gen_tx: main instance at BAUDRATE=104 plus
// BAUDRATE=2 and BAUDRATE=3 corner instances. Expected tick positions are
// hand-derived; LAT accounts for the registered-output build.
module tb_baud_gen_tx;
    import uart_pkg::*;

`ifdef BAUDGEN_TX_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int P = 104;

    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;
    int   ntick;
    logic exp;

    baud_gen_tx_if bus ();
    baud_gen_tx_if b2 ();
    baud_gen_tx_if b3 ();

    baud_gen_tx #(.BAUDRATE(B115200)) dut  (.clk(clk), .rstn(rstn), .bus(bus));
    baud_gen_tx #(.BAUDRATE(2))       dut2 (.clk(clk), .rstn(rstn), .bus(b2));
    baud_gen_tx #(.BAUDRATE(3))       dut3 (.clk(clk), .rstn(rstn), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0b expected %0b", tag, got, want);
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    endtask

    // Drive one cycle's inputs just after the rising edge, settle to mid-cycle
    task automatic cyc(input logic r, input logic e, input logic e23);
        @(posedge clk);
        #1;
        rstn       = r;
        bus.clk_ena = e;
        b2.clk_ena  = e23;
        b3.clk_ena  = e23;
        #4;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rstn = 1'b0;
        bus.clk_ena = 1'b0;
        b2.clk_ena = 1'b0;
        b3.clk_ena = 1'b0;

        // Reset held 3 cycles, disabled
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check("rst_out", bus.clk_out, 1'b0);
            check("rst_out_b2", b2.clk_out, 1'b0);
            check("rst_out_b3", b3.clk_out, 1'b0);
        end

        // 500 disabled cycles: no tick
        for (int c = 0; c < 500; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("idle", bus.clk_out, 1'b0);
        end

        // Enable for 11 bit periods: ticks at 1+LAT+k*104
        ntick = 0;
        for (int c = 0; c < 11 * P; c++) begin
            cyc(1'b1, 1'b1, 1'b0);
            exp = (c >= 1 + LAT) && ((c - 1 - LAT) % P == 0);
            check("en_tick", bus.clk_out, exp);
            if (bus.clk_out === 1'b1) ntick++;
        end
        check_int("en_count", ntick, 11);

        // Drop enable, then fresh enable: tick at 1+LAT, drop 50 cycles later
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("gap", bus.clk_out, 1'b0);
        end
        for (int c = 0; c < 51 + LAT; c++) begin
            cyc(1'b1, 1'b1, 1'b0);
            check("pre_drop", bus.clk_out, c == 1 + LAT);
        end
        for (int c = 0; c < 7; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("dropped", bus.clk_out, 1'b0);
        end
        // Re-raise: phase restarts, tick 1+LAT after re-raise
        for (int c = 0; c < P + 1 + LAT; c++) begin
            cyc(1'b1, 1'b1, 1'b0);
            check("reraise", bus.clk_out, c == 1 + LAT);
        end
        // Drop exactly where the next tick would appear: output must stay low
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("drop_on_tick", bus.clk_out, 1'b0);
        end

        // One-cycle enable pulse from pre-armed state: no tick
        cyc(1'b1, 1'b1, 1'b0);
        check("pulse_en", bus.clk_out, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("pulse_after", bus.clk_out, 1'b0);
        end

        // Reset mid-count while enabled, 30 cycles after a tick
        ntick = 0;
        for (int c = 0; c < 260; c++) begin
            cyc((c == 31) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            if (c < 32)
                exp = (c == 1 + LAT);
            else
                exp = (c >= 32 + LAT) && ((c - 32 - LAT) % P == 0);
            check("mid_rst", bus.clk_out, exp);
            if (bus.clk_out === 1'b1) ntick++;
        end
        check_int("mid_rst_count", ntick, 4);

        // BAUDRATE=2 and 3 corners, continuous enable
        for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 30; c++) begin
            cyc(1'b1, 1'b0, 1'b1);
            check("b2_tick", b2.clk_out, (c >= 1 + LAT) && ((c - 1 - LAT) % 2 == 0));
            check("b3_tick", b3.clk_out, (c >= 1 + LAT) && ((c - 1 - LAT) % 3 == 0));
            check("b3_range", dut3.divcounter < 2'd3, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
